// File: rtl/nettlp_pkg.sv
// Arbiter state encoding and requester limits.
package nettlp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ARB_STATE;

    localparam int unsigned PCIE_TX_MAX_REQ = 8;

endpackage

// File: rtl/pcie_tlp_pkg.sv
// Stream payload types shared by the PCIe TX datapath.
package pcie_tlp_pkg;

    localparam int unsigned PCIE_TX_DATA_W = 64;
    localparam int unsigned PCIE_TX_KEEP_W = 8;
    localparam int unsigned PCIE_TX_USER_W = 4;

    typedef struct packed {
        logic                      tvalid;
        logic                      tlast;
        logic [PCIE_TX_KEEP_W-1:0] tkeep;
        logic [PCIE_TX_DATA_W-1:0] tdata;
        logic [PCIE_TX_USER_W-1:0] tuser;
    } PCIE_TX_STREAM64;

endpackage

// File: rtl/pcie_tx_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1.
module pcie_tx_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic [NUM_REQ-1:0] onehot_c
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                   input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    // Walk offsets high to low so the nearest requester after last_grant wins.
    always_comb begin
        valid_c  = 1'b0;
        idx_c    = '0;
        onehot_c = '0;
        for (int unsigned off = NUM_REQ; off >= 1; off--) begin
            if (req[wrap_idx(last_grant, off)]) begin
                valid_c  = 1'b1;
                idx_c    = wrap_idx(last_grant, off);
                onehot_c = NUM_REQ'(1) << wrap_idx(last_grant, off);
            end
        end
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Round-robin arbiter sharing the 64-bit PCIe TX stream port between NUM_REQ TLP sources,
// one whole TLP per grant, with a mid-TLP stall watchdog and per-source TLP counters.
module pcie_tx_arbiter
    import pcie_tlp_pkg::*;
    import nettlp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                                pcie_clk,
    input  logic                                pcie_rst_n,
    input  logic [NUM_REQ-1:0]                  pcie_tx_req,
    output logic [NUM_REQ-1:0]                  pcie_tx_ack,
    input  logic [NUM_REQ-1:0]                  s_tvalid,
    input  logic [NUM_REQ-1:0]                  s_tlast,
    input  logic [NUM_REQ*PCIE_TX_KEEP_W-1:0]   s_tkeep,
    input  logic [NUM_REQ*PCIE_TX_DATA_W-1:0]   s_tdata,
    input  logic [NUM_REQ*PCIE_TX_USER_W-1:0]   s_tuser,
    output logic [NUM_REQ-1:0]                  s_tready,
    output logic                                m_tvalid,
    output logic                                m_tlast,
    output logic [PCIE_TX_KEEP_W-1:0]           m_tkeep,
    output logic [PCIE_TX_DATA_W-1:0]           m_tdata,
    output logic [PCIE_TX_USER_W-1:0]           m_tuser,
    input  logic                                m_tready,
    output logic                                timeout_pulse,
    output logic                                proto_err,
    output logic [NUM_REQ*CNT_W-1:0]            tlp_cnt
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // Async assert, release synchronised to pcie_clk.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) rst_sync <= 2'b00;
        else             rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    ARB_STATE             state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 in_pkt_q, in_pkt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 proto_err_q, proto_err_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     cnt_q [NUM_REQ];
    logic [CNT_W-1:0]     cnt_d [NUM_REQ];

    PCIE_TX_STREAM64      src [NUM_REQ];
    PCIE_TX_STREAM64      strm_c;
    logic                 accept_c;
    logic                 req_g_c;
    logic                 wd_expire_c;
    logic                 pick_valid_c;
    logic [IDX_W-1:0]     pick_idx_c;
    logic [NUM_REQ-1:0]   pick_onehot_c;

    pcie_tx_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (pcie_tx_req),
        .last_grant (last_grant_q),
        .valid_c    (pick_valid_c),
        .idx_c      (pick_idx_c),
        .onehot_c   (pick_onehot_c)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            src[i].tvalid = s_tvalid[i];
            src[i].tlast  = s_tlast[i];
            src[i].tkeep  = s_tkeep[i*PCIE_TX_KEEP_W +: PCIE_TX_KEEP_W];
            src[i].tdata  = s_tdata[i*PCIE_TX_DATA_W +: PCIE_TX_DATA_W];
            src[i].tuser  = s_tuser[i*PCIE_TX_USER_W +: PCIE_TX_USER_W];
        end
    end

    // Zero-latency mux from the grant register; everything is quiet outside BUSY.
    always_comb begin
        strm_c   = '0;
        s_tready = '0;
        if (state_q == BUSY) begin
            strm_c            = src[grant_q];
            s_tready[grant_q] = m_tready;
        end
    end

    assign m_tvalid = strm_c.tvalid;
    assign m_tlast  = strm_c.tlast;
    assign m_tkeep  = strm_c.tkeep;
    assign m_tdata  = strm_c.tdata;
    assign m_tuser  = strm_c.tuser;

    assign accept_c    = strm_c.tvalid & m_tready;
    assign req_g_c     = pcie_tx_req[grant_q];
    assign wd_expire_c = (TIMEOUT != 0) && in_pkt_q && !accept_c && (wd_q == WD_LAST);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack_d        = ack_q;
        in_pkt_d     = in_pkt_q;
        wd_d         = wd_q;
        proto_err_d  = proto_err_q;
        timeout_d    = 1'b0;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d  = BUSY;
                    grant_d  = pick_idx_c;
                    ack_d    = pick_onehot_c;
                    in_pkt_d = 1'b0;
                    wd_d     = '0;
                end
            end
            BUSY: begin
                if (!req_g_c && in_pkt_q) proto_err_d = 1'b1;
                // Exits in priority order: tlast, watchdog, request withdrawn between TLPs.
                if ((accept_c && strm_c.tlast) || wd_expire_c || (!req_g_c && !in_pkt_q)) begin
                    state_d      = IDLE;
                    ack_d        = '0;
                    last_grant_d = grant_q;
                    in_pkt_d     = 1'b0;
                    wd_d         = '0;
                    if (accept_c && strm_c.tlast) cnt_d[grant_q] = cnt_q[grant_q] + CNT_W'(1);
                    else if (wd_expire_c)         timeout_d = 1'b1;
                end else if (accept_c) begin
                    in_pkt_d = 1'b1;
                    wd_d     = '0;
                end else if (in_pkt_q && (TIMEOUT != 0)) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            ack_q        <= '0;
            in_pkt_q     <= 1'b0;
            wd_q         <= '0;
            proto_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            in_pkt_q     <= in_pkt_d;
            wd_q         <= wd_d;
            proto_err_q  <= proto_err_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pcie_tx_ack   = ack_q;
    assign proto_err     = proto_err_q;
    assign timeout_pulse = timeout_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) tlp_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Randomised bench for pcie_tx_arbiter: transaction-level reference model feeding a beat scoreboard.
module tb_pcie_tx_arbiter;

    localparam int NR = 3;
    localparam int TO = 16;
    localparam int CW = 4;

    logic              pcie_clk = 1'b0;
    logic              pcie_rst_n = 1'b1;
    logic [NR-1:0]     pcie_tx_req = '0;
    logic [NR-1:0]     pcie_tx_ack;
    logic [NR-1:0]     s_tvalid = '0;
    logic [NR-1:0]     s_tlast = '0;
    logic [NR*8-1:0]   s_tkeep = '0;
    logic [NR*64-1:0]  s_tdata = '0;
    logic [NR*4-1:0]   s_tuser = '0;
    logic [NR-1:0]     s_tready;
    logic              m_tvalid, m_tlast;
    logic [7:0]        m_tkeep;
    logic [63:0]       m_tdata;
    logic [3:0]        m_tuser;
    logic              m_tready = 1'b0;
    logic              timeout_pulse, proto_err;
    logic [NR*CW-1:0]  tlp_cnt;

    always #5 pcie_clk = ~pcie_clk;

    pcie_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .pcie_clk      (pcie_clk),
        .pcie_rst_n    (pcie_rst_n),
        .pcie_tx_req   (pcie_tx_req),
        .pcie_tx_ack   (pcie_tx_ack),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tkeep       (s_tkeep),
        .s_tdata       (s_tdata),
        .s_tuser       (s_tuser),
        .s_tready      (s_tready),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tkeep       (m_tkeep),
        .m_tdata       (m_tdata),
        .m_tuser       (m_tuser),
        .m_tready      (m_tready),
        .timeout_pulse (timeout_pulse),
        .proto_err     (proto_err),
        .tlp_cnt       (tlp_cnt)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic [3:0]  u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Source behaviour: each source owns at most one TLP of src_len beats.
    bit          src_req [NR];
    bit          src_has [NR];
    bit          src_vld [NR];
    int          src_len [NR];
    int          src_idx [NR];
    logic [63:0] src_dat [NR];
    logic [7:0]  src_kp  [NR];
    logic [3:0]  src_us  [NR];
    bit          mtr;
    int          stall_left;
    bit          stim_en;
    bit          chk_first;

    // Reference model: who owns the port, whether a TLP is open, cycles since its last beat.
    bit mb;
    int mg, mlast, mstall;
    bit minp, mproto, mpulse;
    int mcnt [NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic new_beat(input int i);
        src_dat[i] = {$urandom, $urandom};
        src_kp[i]  = 8'($urandom);
        src_us[i]  = 4'($urandom);
    endtask

    task automatic new_pkt(input int i);
        src_has[i] = 1'b1;
        src_req[i] = 1'b1;
        src_len[i] = int'($urandom_range(1, 4));
        src_idx[i] = 0;
        new_beat(i);
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NR; i++) begin
            src_req[i] = 1'b0; src_has[i] = 1'b0; src_vld[i] = 1'b0;
            src_len[i] = 1;    src_idx[i] = 0;    new_beat(i);
        end
        mtr = 1'b0;
        stall_left = 0;
    endtask

    task automatic model_reset();
        mb = 1'b0; mg = 0; mlast = NR - 1; mstall = 0;
        minp = 1'b0; mproto = 1'b0; mpulse = 1'b0;
        for (int i = 0; i < NR; i++) mcnt[i] = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            pcie_tx_req[i]        = src_req[i];
            s_tvalid[i]           = src_vld[i];
            s_tlast[i]            = (src_idx[i] == src_len[i] - 1);
            s_tdata[i*64 +: 64]   = src_dat[i];
            s_tkeep[i*8 +: 8]     = src_kp[i];
            s_tuser[i*4 +: 4]     = src_us[i];
        end
        m_tready = mtr;
    endtask

    task automatic decide();
        for (int i = 0; i < NR; i++) begin
            if (!src_has[i]) begin
                if ($urandom_range(0, 2) == 0) new_pkt(i);
            end else if (src_req[i] && $urandom_range(0, 59) == 0) begin
                src_req[i] = 1'b0;
                if (src_idx[i] == 0) src_has[i] = 1'b0;
            end
            src_vld[i] = src_has[i] && ($urandom_range(0, 3) != 0);
        end
        if (stall_left > 0) begin
            mtr = 1'b0;
            stall_left--;
        end else if ($urandom_range(0, 49) == 0) begin
            stall_left = int'($urandom_range(5, 30));
            mtr = 1'b0;
        end else begin
            mtr = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance model and sources past the next edge.
    task automatic step();
        logic [63:0] exp_ack, exp_rdy;
        bit exp_v, acc, lastb, pulse_n;
        int g;
        g = mg;
        exp_ack = mb ? (64'd1 << g) : 64'd0;
        check("ack", 64'(pcie_tx_ack), exp_ack);
        if (chk_first) begin
            check("first_grant_src0", 64'(pcie_tx_ack), 64'd1);
            chk_first = 1'b0;
        end
        check("timeout_pulse", 64'(timeout_pulse), 64'(mpulse));
        check("proto_err", 64'(proto_err), 64'(mproto));
        for (int i = 0; i < NR; i++) check("tlp_cnt", 64'(tlp_cnt[i*CW +: CW]), 64'(mcnt[i]));
        exp_v   = mb && src_vld[g];
        exp_rdy = (mb && mtr) ? exp_ack : 64'd0;
        check("s_tready", 64'(s_tready), exp_rdy);
        check("m_tvalid", 64'(m_tvalid), 64'(exp_v));
        check("m_tdata_live", m_tdata, mb ? src_dat[g] : 64'd0);
        acc   = exp_v && mtr;
        lastb = (src_idx[g] == src_len[g] - 1);
        if (acc) exp_q.push_back('{d: src_dat[g], k: src_kp[g], u: src_us[g], l: lastb});
        pulse_n = 1'b0;
        if (mb) begin
            if (!src_req[g] && minp) mproto = 1'b1;
            if (acc && lastb) begin
                mb = 1'b0; mlast = g; minp = 1'b0; mstall = 0;
                mcnt[g] = (mcnt[g] + 1) % (1 << CW);
                src_has[g] = 1'b0;
                if (src_req[g] && $urandom_range(0, 1) == 0) new_pkt(g);
                else src_req[g] = 1'b0;
            end else if (minp && !acc && mstall == TO - 1) begin
                mb = 1'b0; mlast = g; minp = 1'b0; mstall = 0;
                pulse_n = 1'b1;
                src_idx[g] = 0;
                new_beat(g);
                if (!src_req[g]) src_has[g] = 1'b0;
            end else if (!src_req[g] && !minp) begin
                mb = 1'b0; mlast = g; mstall = 0;
            end else if (acc) begin
                minp = 1'b1; mstall = 0;
                src_idx[g]++;
                new_beat(g);
            end else if (minp) begin
                mstall++;
            end
        end else begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (mlast + k) % NR;
                if (src_req[c]) begin
                    mb = 1'b1; mg = c; minp = 1'b0; mstall = 0;
                    break;
                end
            end
        end
        mpulse = pulse_n;
    endtask

    task automatic cycle();
        @(posedge pcie_clk);
        #1;
        if (stim_en) decide();
        drive();
        #1;
        step();
    endtask

    // Async reset at an arbitrary point, then a clean contention where every source asks at once.
    task automatic do_reset();
        @(negedge pcie_clk);
        #1;
        pcie_rst_n = 1'b0;
        #1;
        check("rst_ack", 64'(pcie_tx_ack), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tdata", m_tdata, 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_tlp_cnt", 64'(tlp_cnt), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        check("rst_timeout_pulse", 64'(timeout_pulse), 64'd0);
        stim_en = 1'b0;
        clear_sources();
        drive();
        model_reset();
        exp_q.delete();
        repeat (3) @(posedge pcie_clk);
        @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
        repeat (4) cycle();
        @(posedge pcie_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            new_pkt(i);
            src_vld[i] = 1'b1;
        end
        mtr = 1'b1;
        drive();
        #1;
        step();
        chk_first = 1'b1;
        stim_en = 1'b1;
    endtask

    always @(negedge pcie_clk) begin : monitor
        beat_t b;
        if (pcie_rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_unexpected: got data %0h, expected no beat (t=%0t)", m_tdata, $time);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", m_tdata, b.d);
                check("beat_keep", 64'(m_tkeep), 64'(b.k));
                check("beat_user", 64'(m_tuser), 64'(b.u));
                check("beat_last", 64'(m_tlast), 64'(b.l));
            end
        end
    end

    initial begin
        stim_en   = 1'b0;
        chk_first = 1'b0;
        clear_sources();
        model_reset();
        drive();
        do_reset();
        repeat (2000) cycle();
        for (int w = 0; w < 500 && !(mb && minp); w++) cycle();
        do_reset();
        repeat (2000) cycle();
        stim_en = 1'b0;
        @(negedge pcie_clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Round-robin arbiter that shares the single 64-bit PCIe TX AXI-Stream port of the endpoint core between NUM_REQ TLP sources (e.g. the eth_decap FIFO drain path and local completion/DMA generators). Each source uses the existing pcie_tx_req/pcie_tx_ack handshake. The arbiter grants one source at a time and holds the grant for exactly one TLP, i.e. until a tlast beat is accepted. It muxes the granted stream to the core, with a stall watchdog and per-source TLP counters for debug.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- TIMEOUT, 1024: cycles without an accepted beat mid-TLP before forced release; 0 disables the watchdog.
- CNT_W, 16: width of each per-requester TLP counter.
- pcie_clk  in  1  PCIe user clock; the only clock.
- pcie_rst_n  in  1  reset, asynchronous assert, active-low (already decided).
- pcie_tx_req  in  NUM_REQ  per-source request; level, held while the source wants the port.
- pcie_tx_ack  out  NUM_REQ  one-hot grant, registered.
- s_tvalid / s_tlast  in  NUM_REQ each  per-source stream qualifiers.
- s_tkeep  in  NUM_REQ x 8  per-source keep.
- s_tdata  in  NUM_REQ x 64  per-source data.
- s_tuser  in  NUM_REQ x 4  per-source TX tuser.
- s_tready  out  NUM_REQ  ready back to each source; only the granted bit may be 1.
- m_tvalid, m_tlast, m_tkeep, m_tdata, m_tuser  out  1/1/8/64/4  stream to the core TX port.
- m_tready  in  1  core ready.
- timeout_pulse  out  1  one-cycle pulse on a watchdog release.
- proto_err  out  1  sticky flag; set when the granted source drops its request mid-TLP. Cleared only by reset.
- tlp_cnt  out  NUM_REQ x CNT_W  accepted-TLP count per source; wraps.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - If any pcie_tx_req bit is set, pick the first set bit searching upward from last_grant+1 (mod NUM_REQ).
  - Register grant index and one-hot ack; go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - m_* = s_*[grant]; s_tready[grant] = m_tready; all other s_tready = 0.
  - A beat is accepted when m_tvalid && m_tready.
  - in_pkt sets on an accepted non-last beat and clears on an accepted tlast beat.
- Exits from BUSY (checked in this priority order):
  - Accepted tlast beat: go to IDLE, last_grant <= grant, tlp_cnt[grant]++.
  - Watchdog expiry: go to IDLE, last_grant <= grant, pulse timeout_pulse, clear in_pkt, no count.
  - pcie_tx_req[grant]==0 with in_pkt==0: go to IDLE, last_grant <= grant, no count.
- pcie_tx_req[grant]==0 with in_pkt==1: set proto_err and keep the grant. The TLP must still end with tlast or a timeout.
- Watchdog:
  - Counter runs only in BUSY with in_pkt==1.
  - Resets to 0 on every accepted beat.
  - Expires when it reaches TIMEOUT-1 with no accepted beat.
- Non-BUSY outputs: all m_* = 0 and all s_tready = 0.
- Requests that arrive at the same time: round-robin from last_grant+1, so no source is starved. With every source requesting continuously, grants rotate 0,1,…,NUM_REQ-1,0.
- tlp_cnt: modulo 2^CNT_W; wrap is silent.

## Timing
- Reset (async, pcie_rst_n=0): state=IDLE, pcie_tx_ack=0, grant=0, last_grant=NUM_REQ-1 (so source 0 wins first), in_pkt=0, watchdog=0, proto_err=0, tlp_cnt=0, timeout_pulse=0. All m_* and s_tready are 0.
- Reset asserted mid-TLP aborts immediately, with no tlast emitted. Release is synchronised internally to pcie_clk.
- Request to grant: req seen in IDLE at edge N gives pcie_tx_ack high after edge N+1. Data mux is live in that same cycle.
- Stream path: purely combinational, zero-latency mux from grant register to m_* and from m_tready to s_tready.
- Release: tlast accepted at edge T gives ack=0 and IDLE after T. The earliest next ack is after T+1, giving one bubble cycle per TLP.
- Single-beat TLP (tvalid+tlast accepted in the first BUSY cycle) is legal.
- m_tvalid may be held with m_tready=0 indefinitely until the watchdog fires. Data must remain the granted source's data throughout.
- timeout_pulse is high for exactly the cycle after expiry, together with ack dropping.

## Structure
- pcie_tlp_pkg gains typedef PCIE_TX_STREAM64 (packed struct: tvalid, tlast, tkeep, tdata, tuser). Ports s_* and m_* are built from it.
- nettlp_pkg gains the enum ARB_STATE {IDLE, BUSY} and localparam PCIE_TX_MAX_REQ = 8.
- Sub-module pcie_tx_rr_pick: combinational round-robin picker. Inputs are the request vector and last_grant; outputs are valid, index and one-hot. It is reused by later arbiters.
- Watchdog, state register and counters live in pcie_tx_arbiter.

## Test plan
- Single source, NUM_REQ=2: req0 held, 3-beat TLP, m_tready=1 → ack0 one cycle after req; m_tdata equals the source data on 3 beats; ack0 low after the tlast edge; tlp_cnt[0]=1.
- Both requesting continuously, 2-beat TLPs → grants alternate 0,1,0,1 with one idle bubble between TLPs; after 4 TLPs tlp_cnt[0]=2 and tlp_cnt[1]=2.
- Backpressure: m_tready=0 for 50 cycles mid-TLP, TIMEOUT=1024 → m_* are held stable, no release, s_tready[grant]=0, and no s_tready is asserted for the other source.
- Stall with TIMEOUT=16: no beats after the first → timeout_pulse high in cycle 17 after the last beat; ack drops; the next requester is granted; tlp_cnt is unchanged.
- req0 dropped after beat 1 of 4 → proto_err=1; grant held until tlast; count incremented. req0 dropped before any beat → release with no error and no count.
- Reset asserted mid-TLP → all outputs 0 immediately. After release, source 0 wins the first contention; tlp_cnt wraps from 0xFFFF to 0 when CNT_W=16.
